// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types and helpers for the EX/MEM pipeline register.
//   pipe_state_e     occupancy state of the skid buffer (EMPTY, ONE, TWO)
//   payload_w()      payload width for a given field configuration
//   ex_mem_payload_t payload record for the default 32-bit MIPS configuration
//   pack_payload / unpack_payload  convert between the record and a flat vector
package ex_mem_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_AW_DEF     = 5;
  localparam int unsigned MEMTOREG_W_DEF = 2;

  // regwrite + memtoreg + memwrite + alu_out + write_data + pc_8 + write_reg
  function automatic int unsigned payload_w(input int unsigned data_w,
                                            input int unsigned reg_aw,
                                            input int unsigned memtoreg_w);
    return 1 + memtoreg_w + 1 + 3 * data_w + reg_aw;
  endfunction

  localparam int unsigned EX_MEM_PAYLOAD_W =
    payload_w(DATA_W_DEF, REG_AW_DEF, MEMTOREG_W_DEF);

  // Field order here defines the flat vector layout (regwrite is the MSB).
  typedef struct packed {
    logic                      regwrite;
    logic [MEMTOREG_W_DEF-1:0] memtoreg;
    logic                      memwrite;
    logic [DATA_W_DEF-1:0]     alu_out;
    logic [DATA_W_DEF-1:0]     write_data;
    logic [REG_AW_DEF-1:0]     write_reg;
    logic [DATA_W_DEF-1:0]     pc_8;
  } ex_mem_payload_t;

  function automatic logic [EX_MEM_PAYLOAD_W-1:0] pack_payload(input ex_mem_payload_t p);
    return EX_MEM_PAYLOAD_W'(p);
  endfunction

  function automatic ex_mem_payload_t unpack_payload(input logic [EX_MEM_PAYLOAD_W-1:0] v);
    return ex_mem_payload_t'(v);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic valid/ready payload register with synchronous flush.
//   SKID=1: two-entry skid buffer, registered in_ready (no path from out_ready).
//   SKID=0: single register, in_ready = !out_valid || out_ready (combinational).
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   flush           drop every held entry and any same-cycle input
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter bit          SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (SKID) begin : g_skid

    pipe_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             in_fire;
    logic             out_fire;

    // main always holds the oldest entry; skid only fills while main is stalled
    assign out_valid = (state_q == ONE) || (state_q == TWO);
    assign out_data  = main_q;
    assign in_ready  = in_ready_q;
    assign in_fire   = in_valid && in_ready_q;
    assign out_fire  = out_valid && out_ready;

    // Next-state and data-path steering
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
      // Flush empties the buffer but leaves the data registers untouched
      if (flush) begin
        state_d = EMPTY;
        main_d  = main_q;
        skid_d  = skid_q;
      end
    end

    // State and data registers; in_ready is precomputed from the next state
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q    <= EMPTY;
        main_q     <= '0;
        skid_q     <= '0;
        in_ready_q <= 1'b1;
      end else begin
        state_q    <= state_d;
        main_q     <= main_d;
        skid_q     <= skid_d;
        in_ready_q <= (state_d != TWO);
      end
    end

  end else begin : g_single

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign in_ready  = !valid_q || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = valid_q && out_ready;

    // Load on accept, clear valid on a drain with no replacement
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_fire) begin
        data_d  = in_data;
        valid_d = 1'b1;
      end else if (out_fire) begin
        valid_d = 1'b0;
      end
      if (flush) begin
        valid_d = 1'b0;
        data_d  = data_q;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

  end

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register for the 5-stage MIPS pipeline with
// valid/ready handshake, synchronous flush and optional two-entry skid buffer.
// Ports:
//   clk, reset, flush               clock, sync active-high reset, redirect kill
//   in_valid, in_ready              EX-side handshake
//   regwrite_e .. pc_8_e            EX-side payload
//   out_valid, out_ready            MEM-side handshake
//   regwrite_m .. pc_8_m            MEM-side payload (write enables gated by out_valid)
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MEMTOREG_W = 2,
  parameter bit          SKID       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  regwrite_e,
  input  logic [MEMTOREG_W-1:0] memtoreg_e,
  input  logic                  memwrite_e,
  input  logic [DATA_W-1:0]     alu_out_e,
  input  logic [DATA_W-1:0]     write_data_e,
  input  logic [REG_AW-1:0]     write_reg_e,
  input  logic [DATA_W-1:0]     pc_8_e,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  regwrite_m,
  output logic [MEMTOREG_W-1:0] memtoreg_m,
  output logic                  memwrite_m,
  output logic [DATA_W-1:0]     alu_out_m,
  output logic [DATA_W-1:0]     write_data_m,
  output logic [REG_AW-1:0]     write_reg_m,
  output logic [DATA_W-1:0]     pc_8_m
);

  localparam int unsigned PW = payload_w(DATA_W, REG_AW, MEMTOREG_W);

  logic [PW-1:0] in_data;
  logic [PW-1:0] out_data;
  logic          regwrite_raw;
  logic          memwrite_raw;

  // Default configuration goes through the package record; other widths use
  // the same field order with a plain concatenation.
  if (DATA_W == DATA_W_DEF && REG_AW == REG_AW_DEF && MEMTOREG_W == MEMTOREG_W_DEF)
  begin : g_rec
    ex_mem_payload_t in_rec;
    ex_mem_payload_t out_rec;

    assign in_rec = '{regwrite:   regwrite_e,
                      memtoreg:   memtoreg_e,
                      memwrite:   memwrite_e,
                      alu_out:    alu_out_e,
                      write_data: write_data_e,
                      write_reg:  write_reg_e,
                      pc_8:       pc_8_e};
    assign in_data  = pack_payload(in_rec);
    assign out_rec  = unpack_payload(out_data);

    assign regwrite_raw = out_rec.regwrite;
    assign memtoreg_m   = out_rec.memtoreg;
    assign memwrite_raw = out_rec.memwrite;
    assign alu_out_m    = out_rec.alu_out;
    assign write_data_m = out_rec.write_data;
    assign write_reg_m  = out_rec.write_reg;
    assign pc_8_m       = out_rec.pc_8;
  end else begin : g_cat
    assign in_data = {regwrite_e, memtoreg_e, memwrite_e, alu_out_e,
                      write_data_e, write_reg_e, pc_8_e};
    assign {regwrite_raw, memtoreg_m, memwrite_raw, alu_out_m,
            write_data_m, write_reg_m, pc_8_m} = out_data;
  end

  pipe_skid_buf #(
    .WIDTH (PW),
    .SKID  (SKID)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // A bubble must never write the register file or data memory
  assign regwrite_m = out_valid & regwrite_raw;
  assign memwrite_m = out_valid & memwrite_raw;

endmodule
